// File: rtl/async_receiver_if.sv
// async_receiver_if: serial line plus received-byte outputs of the RS-232 receiver.
//   RxD             serial line into the receiver (idle high)
//   RxD_data        last good byte
//   RxD_data_ready  one-cycle strobe, RxD_data updated
//   RxD_frame_error one-cycle strobe, stop bit sampled low
//   RxD_busy        frame in progress
interface async_receiver_if;
  logic RxD;
  logic [7:0] RxD_data;
  logic RxD_data_ready;
  logic RxD_frame_error;
  logic RxD_busy;
  modport master(output RxD, input RxD_data, RxD_data_ready, RxD_frame_error, RxD_busy);
  modport slave(input RxD, output RxD_data, RxD_data_ready, RxD_frame_error, RxD_busy);
endinterface

// File: rtl/async_receiver.sv
// async_receiver: 8N1 RS-232 receiver with 16x oversampling phase-accumulator baud generator.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    async_receiver_if.slave: RxD in; RxD_data, RxD_data_ready, RxD_frame_error, RxD_busy out
module async_receiver #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud = 115200,
  parameter int Oversampling = 16,
  parameter int BaudGeneratorAccWidth = 16
) (
  input logic clk,
  input logic rst_n,
  async_receiver_if.slave bus
);
  localparam int W = BaudGeneratorAccWidth;
  localparam logic [63:0] INC64 =
    (((64'(Baud) * 64'(Oversampling)) << W) + 64'(ClkFrequency) / 64'd2) / 64'(ClkFrequency);
  localparam logic [W:0] INC = INC64[W:0];
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic [W:0] acc;
  logic tick;
  logic [1:0] sync;
  logic [1:0] cnt;
  logic filt;
  logic [3:0] os_cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  // the carry out of the accumulator is the 16x oversampling tick
  assign tick = acc[W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      sync <= 2'b11;
      cnt <= 2'd3;
      filt <= 1'b1;
    end else begin
      acc <= {1'b0, acc[W-1:0]} + INC;
      sync <= {sync[0], bus.RxD};
      if (tick && sync[1] && cnt != 2'd3) cnt <= cnt + 2'd1;
      else if (tick && !sync[1] && cnt != 2'd0) cnt <= cnt - 2'd1;
      // hysteresis: only a saturated count flips the filtered bit
      filt <= cnt == 2'd3 ? 1'b1 : cnt == 2'd0 ? 1'b0 : filt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      os_cnt <= '0;
      idx <= '0;
      shift <= '0;
      bus.RxD_data <= '0;
      bus.RxD_data_ready <= 1'b0;
      bus.RxD_frame_error <= 1'b0;
      bus.RxD_busy <= 1'b0;
    end else begin
      bus.RxD_data_ready <= 1'b0;
      bus.RxD_frame_error <= 1'b0;
      if (tick) begin
        os_cnt <= os_cnt + 4'd1;
        case (state)
          IDLE:
            if (!filt) begin
              state <= START;
              os_cnt <= '0;
              bus.RxD_busy <= 1'b1;
            end
          START:
            if (os_cnt == 4'd7 && filt) begin
              state <= IDLE;
              bus.RxD_busy <= 1'b0;
            end else if (os_cnt == 4'd15) begin
              state <= DATA;
              idx <= '0;
            end
          DATA: begin
            if (os_cnt == 4'd7) shift <= {filt, shift[7:1]};
            if (os_cnt == 4'd15) begin
              idx <= idx + 3'd1;
              if (idx == 3'd7) state <= STOP;
            end
          end
          STOP:
            // leaving at mid-stop lets a back-to-back start bit be caught on time
            if (os_cnt == 4'd7) begin
              bus.RxD_busy <= 1'b0;
              if (filt) begin
                bus.RxD_data <= shift;
                bus.RxD_data_ready <= 1'b1;
                state <= IDLE;
              end else begin
                bus.RxD_frame_error <= 1'b1;
                state <= WAIT_HIGH;
              end
            end
          WAIT_HIGH:
            // a held-low line must rise before a new start bit is accepted
            if (filt) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: doc/async_receiver.md
# async_receiver

RS-232 receive block; the receive-side counterpart of the UART transmitter in this design. It recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the asynchronous RxD line using a 16x oversampling phase-accumulator baud generator. Each good byte is presented as a one-cycle strobe plus data. Framing errors are reported as a separate strobe.

## Interface
- ClkFrequency, 50000000: clk frequency in Hz.
- Baud, 115200: line bit rate.
- Oversampling, 16: ticks per bit, fixed at 16; other values are not supported.
- BaudGeneratorAccWidth, 16: accumulator width W. The accumulator register is W+1 bits, and bit W is the carry/tick.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RxD  input  1  serial line, idle high, asynchronous to clk.
- RxD_data  output  8  last good byte; holds until the next good byte.
- RxD_data_ready  output  1  one-cycle strobe: RxD_data updated this cycle.
- RxD_frame_error  output  1  one-cycle strobe: stop bit sampled low.
- RxD_busy  output  1  high while a frame is in progress (START/DATA/STOP).

## Operation
- **Reset values:** RxD_data=0, RxD_data_ready=0, RxD_frame_error=0, RxD_busy=0. Sync flops=1, filter count=3, filtered bit=1, state=IDLE, accumulator=0.
- **Baud tick generator:**
  - Inc = round(Baud*16*2^W/ClkFrequency), evaluated in 64-bit arithmetic at elaboration.
  - The accumulator runs continuously (not gated by busy): acc <= acc[W-1:0] + Inc.
  - tick = acc[W].
- **Input path:**
  - RxD passes through a 2-flop synchronizer.
  - A 2-bit saturating filter updates on tick only: synced 1 and cnt<3 → cnt+1; synced 0 and cnt>0 → cnt-1.
  - The filtered bit is set to 1 when cnt==3 and cleared to 0 when cnt==0; otherwise it holds.
- **os_cnt:** 4-bit oversample counter, increments on tick, wraps 15→0.
- **State machine:** IDLE, START, DATA, STOP, WAIT_HIGH. A 3-bit bit index is used in DATA. All transitions occur only on tick.
  - **IDLE:** filtered=0 → START, os_cnt=0.
  - **START:** at the tick with os_cnt==7, if filtered=1 → IDLE (glitch rejection, no strobe). At the tick with os_cnt==15 → DATA, index 0.
  - **DATA:** at os_cnt==7, shift the filtered bit into the shift register MSB with a right shift (LSB first). At os_cnt==15, index 7 → STOP; otherwise index+1.
  - **STOP:** at os_cnt==7:
    - filtered=1 → RxD_data <= shift register, RxD_data_ready=1 next cycle, state → IDLE.
    - filtered=0 → RxD_frame_error=1 next cycle, RxD_data unchanged, state → WAIT_HIGH.
  - **WAIT_HIGH:** filtered=1 → IDLE. This prevents a held-low line (break) from retriggering a frame.
- Returning to IDLE at mid-stop lets the receiver accept a back-to-back start bit that begins at the nominal stop-bit end.
- RxD_data_ready and RxD_frame_error are never high in the same cycle.
- **Reset mid-frame:** all state is abandoned immediately, with no strobe. After reset deassertion a new frame is recognised only from a fresh falling edge seen in IDLE.

## Timing
- Input latency: 2 clk (synchronizer) plus 2–3 ticks (filter) from a RxD edge to a filtered-bit change. This delay is identical for all edges, so sample points stay centred.
- Sample point is 8 ticks after start detection, +16 ticks per bit thereafter.
- RxD_data_ready rises one clk after the STOP sample tick, lasts exactly 1 clk, and arrives about 9.5 bit-times after the start edge.
- RxD_busy is registered: it rises the cycle after the IDLE→START transition and falls the cycle after leaving STOP. It is low in WAIT_HIGH.
- Tolerates at least ±3% baud mismatch.

## Test plan
Benches use ClkFrequency=3200000, Baud=100000 (tick every 2 clk, 32 clk/bit) unless stated.
- **Single byte 0x53 (8N1):** exactly one RxD_data_ready pulse, RxD_data=0x53, no frame_error, busy high for roughly 10 bit-times minus half a bit.
- **Back-to-back 0x00, 0xFF, 0xA5:** no idle gap between frames. Three ready pulses in order with matching data.
- **Glitch rejection:** a 1-bit-time-short low pulse of 4 clk on idle RxD produces no strobe and busy returns to 0. A low pulse of 10 clk produces START→IDLE with no strobe.
- **Framing error:** byte 0x3C sent with stop bit forced low, then line held low 5 bit-times, then high. One frame_error pulse, RxD_data keeps its previous value, no new frame starts until RxD rises, after which 0x81 is received correctly.
- **Reset mid-frame:** assert rst_n low during bit 4 of 0x5A. All outputs are 0 within the reset, no strobe for the aborted frame, and a following 0x11 is received correctly.
- **Baud tolerance:** with default parameters (Inc=2416), drive the bench baud at +3% and −3% while sending 0x55. Data is correct in both cases.
